spi_req_arbiter: RTL and testbench

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

---
 rtl/spi_req_arbiter.sv | 115 +++++++++++
 tb/tb_spi_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master between two byte-transfer requesters; grant 1 cycle after req in IDLE.
// Requesters hold req until their done pulse; every busy_m wait is bounded by TIMEOUT_CYC, then err flags the transfer.
module spi_req_arbiter #(
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    output logic [1:0] gnt,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rx_data,
    output logic       err,
    output logic [7:0] m_data_send,
    output logic       ss,
    input  logic       busy_m,
    input  logic [7:0] m_rece
);
    typedef enum logic [2:0] {IDLE, START, XFER, DONE, GAP} state_t;

    localparam logic [9:0] TO_LAST  = 10'(TIMEOUT_CYC);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    state_t     state;
    logic [9:0] wait_cnt;
    logic [3:0] gap_cnt;
    logic       last_gnt;
    logic       win;
    logic       wait_expired;

    // A tie goes to whoever was not served last; last_gnt=1 hands the first tie to req0.
    assign win          = req1 & (~req0 | ~last_gnt);
    assign wait_expired = (wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ss          <= 1'b1;
            gnt         <= 2'b00;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err         <= 1'b0;
            rx_data     <= 8'h00;
            m_data_send <= 8'h00;
            wait_cnt    <= 10'd0;
            gap_cnt     <= 4'd0;
            last_gnt    <= 1'b1;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        m_data_send <= win ? tx1 : tx0;
                        gnt         <= win ? 2'b10 : 2'b01;
                        last_gnt    <= win;
                        ss          <= 1'b0;
                        wait_cnt    <= 10'd0;
                        state       <= START;
                    end
                end
                START: begin
                    if (busy_m) begin
                        wait_cnt <= 10'd0;
                        state    <= XFER;
                    end else if (wait_expired) begin
                        rx_data <= 8'h00;
                        done0   <= gnt[0];
                        done1   <= gnt[1];
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                XFER: begin
                    // The counter stops at TO_LAST because expiry leaves the state before any further increment.
                    if (!busy_m) begin
                        rx_data <= m_rece;
                        done0   <= gnt[0];
                        done1   <= gnt[1];
                        state   <= DONE;
                    end else if (wait_expired) begin
                        rx_data <= 8'h00;
                        done0   <= gnt[0];
                        done1   <= gnt[1];
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                DONE: begin
                    ss      <= 1'b1;
                    gnt     <= 2'b00;
                    gap_cnt <= 4'd0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: one default instance and one with TIMEOUT_CYC=8, each served by a behavioural SPI master,
// checked per transaction against a round-robin reference model.
module tb_spi_req_arbiter;
    localparam int GAP = 2;

    logic            clk;
    logic            rst;
    logic [1:0]      req0_v, req1_v, ss_v, busy_v, done0_v, done1_v, err_v;
    logic [1:0][7:0] tx0_v, tx1_v, rx_v, mds_v, mrece_v;
    logic [1:0][1:0] gnt_v;

    int   mode     [2];
    int   blen     [2];
    int   hi_run   [2];
    int   hi_last  [2];
    logic last_win [2];
    logic had_prev [2];

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_req_arbiter #(.GAP_CYC(GAP), .TIMEOUT_CYC(1023)) u_dut (
        .clk(clk), .rst(rst), .req0(req0_v[0]), .req1(req1_v[0]), .tx0(tx0_v[0]), .tx1(tx1_v[0]),
        .gnt(gnt_v[0]), .done0(done0_v[0]), .done1(done1_v[0]), .rx_data(rx_v[0]), .err(err_v[0]),
        .m_data_send(mds_v[0]), .ss(ss_v[0]), .busy_m(busy_v[0]), .m_rece(mrece_v[0])
    );

    spi_req_arbiter #(.GAP_CYC(GAP), .TIMEOUT_CYC(8)) u_dut_to (
        .clk(clk), .rst(rst), .req0(req0_v[1]), .req1(req1_v[1]), .tx0(tx0_v[1]), .tx1(tx1_v[1]),
        .gnt(gnt_v[1]), .done0(done0_v[1]), .done1(done1_v[1]), .rx_data(rx_v[1]), .err(err_v[1]),
        .m_data_send(mds_v[1]), .ss(ss_v[1]), .busy_m(busy_v[1]), .m_rece(mrece_v[1])
    );

    // SPI master model: busy rises 3 samples after ss falls; mode 0 = busy for blen cycles, 1 = never busy, 2 = stuck busy.
    initial begin : spi_master
        int lo [2];
        busy_v = 2'b00;
        lo[0]  = 0;
        lo[1]  = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (ss_v[k] !== 1'b0) lo[k] = 0;
                else lo[k] = lo[k] + 1;
                case (mode[k])
                    0:       busy_v[k] = (lo[k] > 2) && (lo[k] <= 2 + blen[k]);
                    1:       busy_v[k] = 1'b0;
                    default: busy_v[k] = (lo[k] > 2);
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One negedge; also tracks the length of the most recent ss-high run per instance.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (ss_v[k] === 1'b1) begin
                hi_run[k]++;
            end else begin
                if (hi_run[k] != 0) hi_last[k] = hi_run[k];
                hi_run[k] = 0;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_win[k] = 1'b1;
            had_prev[k] = 1'b0;
        end
    endtask

    task automatic run_txn(input int k, input logic r0, input logic r1,
                           input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] rxb,
                           input int m, input int len, input logic mid, input logic [7:0] mid_tx,
                           output int g_lat, output int d_lat);
        int         n;
        int         bsy;
        logic       w;
        logic       to;
        logic       stable;
        logic [1:0] eg;
        logic [7:0] ed;
        logic [7:0] erx;
        to      = (m != 0);
        erx     = to ? 8'h00 : rxb;
        mode[k] = m;
        blen[k] = len;
        mrece_v[k] = rxb;
        req0_v[k]  = r0;
        req1_v[k]  = r1;
        tx0_v[k]   = t0;
        tx1_v[k]   = t1;
        w  = (r0 && r1) ? !last_win[k] : r1;
        eg = w ? 2'b10 : 2'b01;
        ed = w ? t1 : t0;

        n = 0;
        do begin
            step();
            n++;
        end while (gnt_v[k] === 2'b00 && n < 200);
        g_lat = n;
        chk("gnt", 32'(gnt_v[k]), 32'(eg));
        chk("m_data_send", 32'(mds_v[k]), 32'(ed));
        chk("ss_low_at_grant", 32'(ss_v[k]), 0);
        if (had_prev[k]) chk("ss_gap_len", 32'(hi_last[k] >= GAP), 1);
        last_win[k] = w;
        had_prev[k] = 1'b1;

        n      = 0;
        bsy    = 0;
        stable = 1'b1;
        do begin
            step();
            n++;
            if (gnt_v[k] !== eg || mds_v[k] !== ed) stable = 1'b0;
            if (busy_v[k] === 1'b1) bsy++;
            if (mid && bsy == 2) begin
                if (w) begin
                    tx1_v[k]  = mid_tx;
                    req1_v[k] = 1'b0;
                end else begin
                    tx0_v[k]  = mid_tx;
                    req0_v[k] = 1'b0;
                end
            end
        end while (done0_v[k] !== 1'b1 && done1_v[k] !== 1'b1 && n < 2000);
        d_lat = n;
        chk("gnt_data_stable", 32'(stable), 1);
        chk("done0", 32'(done0_v[k]), 32'(!w));
        chk("done1", 32'(done1_v[k]), 32'(w));
        chk("err", 32'(err_v[k]), 32'(to));
        chk("rx_data", 32'(rx_v[k]), 32'(erx));

        step();
        chk("done_single_pulse", 32'({done0_v[k], done1_v[k], err_v[k]}), 0);
        chk("gnt_cleared", 32'(gnt_v[k]), 0);
        chk("ss_released", 32'(ss_v[k]), 1);
        chk("rx_data_held", 32'(rx_v[k]), 32'(erx));
        req0_v[k] = 1'b0;
        req1_v[k] = 1'b0;
    endtask

    initial begin : main
        int   gl, dl, n, v;
        logic seen;
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        req0_v  = 2'b00;
        req1_v  = 2'b00;
        tx0_v   = '0;
        tx1_v   = '0;
        mrece_v = '0;
        for (int k = 0; k < 2; k++) begin
            mode[k]    = 0;
            blen[k]    = 4;
            hi_run[k]  = 0;
            hi_last[k] = 0;
        end
        model_reset();

        repeat (3) step();
        chk("rst_gnt", 32'(gnt_v[0]), 0);
        chk("rst_ss", 32'(ss_v[0]), 1);
        chk("rst_done0", 32'(done0_v[0]), 0);
        chk("rst_done1", 32'(done1_v[0]), 0);
        chk("rst_err", 32'(err_v[0]), 0);
        chk("rst_rx_data", 32'(rx_v[0]), 0);
        chk("rst_m_data_send", 32'(mds_v[0]), 0);
        chk("rst_to_gnt", 32'(gnt_v[1]), 0);
        chk("rst_to_ss", 32'(ss_v[1]), 1);
        chk("rst_to_rx_data", 32'(rx_v[1]), 0);
        rst = 1'b0;

        // Tie from reset with both requests held: 01/45, 10/C3, 01/45.
        for (int i = 0; i < 3; i++)
            run_txn(0, 1'b1, 1'b1, 8'h45, 8'hC3, 8'($urandom), 0, 4, 1'b0, 8'h00, gl, dl);

        repeat (6) step();
        run_txn(0, 1'b1, 1'b0, 8'hAB, 8'h00, 8'h61, 0, 16, 1'b0, 8'h00, gl, dl);
        chk("grant_latency", 32'(gl), 1);

        // tx0 changes to 12 and req0 drops in the middle of the transfer.
        run_txn(0, 1'b1, 1'b0, 8'hAB, 8'h5A, 8'h9E, 0, 8, 1'b1, 8'h12, gl, dl);

        // Reset while busy_m is high.
        mode[0]    = 0;
        blen[0]    = 16;
        mrece_v[0] = 8'h77;
        req0_v[0]  = 1'b1;
        tx0_v[0]   = 8'h3C;
        n = 0;
        do begin
            step();
            n++;
        end while (gnt_v[0] === 2'b00 && n < 200);
        chk("rst_mid_pre_gnt", 32'(gnt_v[0]), 32'(2'b01));
        n = 0;
        v = 0;
        do begin
            step();
            n++;
            if (busy_v[0] === 1'b1) v++;
        end while (v < 3 && n < 200);
        seen = done0_v[0] | done1_v[0];
        rst  = 1'b1;
        step();
        chk("rst_mid_ss", 32'(ss_v[0]), 1);
        chk("rst_mid_gnt", 32'(gnt_v[0]), 0);
        chk("rst_mid_rx_data", 32'(rx_v[0]), 0);
        chk("rst_mid_m_data_send", 32'(mds_v[0]), 0);
        rst       = 1'b0;
        req0_v[0] = 1'b0;
        model_reset();
        repeat (4) begin
            step();
            seen = seen | done0_v[0] | done1_v[0] | err_v[0];
        end
        chk("rst_mid_no_done", 32'(seen), 0);
        run_txn(0, 1'b1, 1'b0, 8'hD2, 8'h00, 8'h4B, 0, 5, 1'b0, 8'h00, gl, dl);
        chk("post_rst_grant_latency", 32'(gl), 1);

        for (int i = 0; i < 24; i++) begin
            v = int'($urandom_range(1, 3));
            run_txn(0, v[0], v[1], 8'($urandom), 8'($urandom), 8'($urandom), 0,
                    int'($urandom_range(1, 10)), 1'($urandom), 8'($urandom), gl, dl);
        end

        // TIMEOUT_CYC=8 instance: normal, start timeout, stuck busy, then recovery.
        run_txn(1, 1'b0, 1'b1, 8'h00, 8'h3E, 8'h5A, 0, 3, 1'b0, 8'h00, gl, dl);
        run_txn(1, 1'b0, 1'b1, 8'h00, 8'h96, 8'hEE, 1, 3, 1'b0, 8'h00, gl, dl);
        chk("start_timeout_latency", 32'((dl == 9) || (dl == 10)), 1);
        run_txn(1, 1'b1, 1'b0, 8'h5C, 8'h00, 8'hEE, 2, 3, 1'b0, 8'h00, gl, dl);
        run_txn(1, 1'b1, 1'b1, 8'h27, 8'hB4, 8'h81, 0, 3, 1'b0, 8'h00, gl, dl);

        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(1, 3));
            run_txn(1, v[0], v[1], 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(1, 5)), 1'($urandom),
                    8'($urandom), gl, dl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
